// File: rtl/gpu_bus_pkg.sv
// -----------------------------------------------------------------------------
// gpu_bus_pkg
// Shared definitions for the GPU register bus: the arbiter state encoding and
// the bus widths used by the SPI bridge, gpu_top and gpu_bus_arbiter.
// No ports (package only).
// -----------------------------------------------------------------------------
package gpu_bus_pkg;

  localparam int GPU_BUS_ADDR_WIDTH = 32;
  localparam int GPU_BUS_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  // Width of an index into a vector of n entries (at least one bit).
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpu_bus_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority selector. Searches upward from last_i+1,
// wrapping from NUM_REQ-1 back to 0, and returns the first requester found.
// Ports:
//   req_i  : request vector
//   last_i : index of the previous winner (lowest priority this round)
//   gnt_o  : one-hot winner (all zero when nothing requests)
//   idx_o  : index of the winner (0 when nothing requests)
// -----------------------------------------------------------------------------
module rr_pick
  import gpu_bus_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idxWidth(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [IDX_W-1:0] cand;

  // Walk the candidates from the farthest offset down to the nearest one, so
  // the requester closest after last_i is the one left standing.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = IDX_W'((int'(last_i) + off) % NUM_REQ);
      if (req_i[cand]) begin
        gnt_o       = '0;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/gpu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// gpu_bus_arbiter
// Round-robin arbiter sharing the GPU register bus between NUM_REQ masters.
// One transaction is in flight at a time; read data is returned to the master
// that issued the read.
// Optional feature: define BUS_ARB_LOCK_EN to honour i_lock for atomic
// sequences (a locked winner keeps the bus until it issues an unlocked access).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   i_req/i_we/i_lock     : per-master request, write flag, lock request
//   i_addr/i_wdata        : per-master address and write data
//   o_gnt                 : one-hot grant pulse (ISSUE cycle)
//   o_rvalid/o_rdata      : one-hot read-return pulse and its data
//   o_bus_valid/o_bus_we  : issue strobe and write strobe towards the bus
//   o_bus_addr/o_bus_wdata: issued address and write data (held)
//   i_bus_rdata           : read data from the bus
// -----------------------------------------------------------------------------
module gpu_bus_arbiter
  import gpu_bus_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = GPU_BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH = GPU_BUS_DATA_WIDTH,
  parameter int RD_LATENCY = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  i_req,
  input  logic [NUM_REQ-1:0]                  i_we,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  i_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  i_wdata,
  input  logic [NUM_REQ-1:0]                  i_lock,
  output logic [NUM_REQ-1:0]                  o_gnt,
  output logic [NUM_REQ-1:0]                  o_rvalid,
  output logic [DATA_WIDTH-1:0]               o_rdata,
  output logic                                o_bus_valid,
  output logic                                o_bus_we,
  output logic [ADDR_WIDTH-1:0]               o_bus_addr,
  output logic [DATA_WIDTH-1:0]               o_bus_wdata,
  input  logic [DATA_WIDTH-1:0]               i_bus_rdata
);

  localparam int IDX_W = idxWidth(NUM_REQ);

  arb_state_t              state_q, state_d;
  logic [IDX_W-1:0]        lastIdx_q, lastIdx_d;
  logic [NUM_REQ-1:0]      winOh_q, winOh_d;
  logic                    busWe_q, busWe_d;
  logic [ADDR_WIDTH-1:0]   busAddr_q, busAddr_d;
  logic [DATA_WIDTH-1:0]   busWdata_q, busWdata_d;
  logic [2:0]              rdLatCnt_q, rdLatCnt_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic [NUM_REQ-1:0]      reqEff;
  logic [NUM_REQ-1:0]      pickOh;
  logic [IDX_W-1:0]        pickIdx;

`ifdef BUS_ARB_LOCK_EN
  logic locked_q, locked_d;

  // While locked only the lock owner (the previous winner) may compete.
  always_comb begin
    reqEff = locked_q ? (i_req & winOh_q) : i_req;
  end
`else
  logic unusedLock;
  assign unusedLock = ^i_lock;

  // Without lock support every request competes every round.
  always_comb begin
    reqEff = i_req;
  end
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) uPick (
    .req_i  (reqEff),
    .last_i (lastIdx_q),
    .gnt_o  (pickOh),
    .idx_o  (pickIdx)
  );

  // Next-state logic. The winner's payload is latched while still in IDLE so
  // it is on the bus outputs during the ISSUE cycle; a read then either
  // captures data straight away or counts down the bus read latency.
  always_comb begin
    state_d    = state_q;
    lastIdx_d  = lastIdx_q;
    winOh_d    = winOh_q;
    busWe_d    = busWe_q;
    busAddr_d  = busAddr_q;
    busWdata_d = busWdata_q;
    rdLatCnt_d = rdLatCnt_q;
    rdata_d    = rdata_q;
`ifdef BUS_ARB_LOCK_EN
    locked_d   = locked_q;
`endif
    case (state_q)
      IDLE: begin
        if (|reqEff) begin
          winOh_d    = pickOh;
          lastIdx_d  = pickIdx;
          busWe_d    = i_we[pickIdx];
          busAddr_d  = i_addr[pickIdx];
          busWdata_d = i_wdata[pickIdx];
`ifdef BUS_ARB_LOCK_EN
          // The payload (lock included) is stable until grant, so sampling it
          // here equals sampling it in the grant cycle.
          locked_d   = i_lock[pickIdx];
`endif
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (busWe_q) begin
          state_d = IDLE;
        end else if (RD_LATENCY == 0) begin
          rdata_d = i_bus_rdata;
          state_d = RESP;
        end else begin
          rdLatCnt_d = 3'(RD_LATENCY - 1);
          state_d    = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (rdLatCnt_q == 3'd0) begin
          rdata_d = i_bus_rdata;
          state_d = RESP;
        end else begin
          rdLatCnt_d = rdLatCnt_q - 3'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. last starts at NUM_REQ-1 so master 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lastIdx_q  <= IDX_W'(NUM_REQ - 1);
      winOh_q    <= '0;
      busWe_q    <= 1'b0;
      busAddr_q  <= '0;
      busWdata_q <= '0;
      rdLatCnt_q <= '0;
      rdata_q    <= '0;
`ifdef BUS_ARB_LOCK_EN
      locked_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      lastIdx_q  <= lastIdx_d;
      winOh_q    <= winOh_d;
      busWe_q    <= busWe_d;
      busAddr_q  <= busAddr_d;
      busWdata_q <= busWdata_d;
      rdLatCnt_q <= rdLatCnt_d;
      rdata_q    <= rdata_d;
`ifdef BUS_ARB_LOCK_EN
      locked_q   <= locked_d;
`endif
    end
  end

  // Outputs come straight from registers, so reset clears them immediately.
  assign o_bus_valid = (state_q == ISSUE);
  assign o_bus_we    = o_bus_valid & busWe_q;
  assign o_gnt       = o_bus_valid ? winOh_q : '0;
  assign o_rvalid    = (state_q == RESP) ? winOh_q : '0;
  assign o_rdata     = rdata_q;
  assign o_bus_addr  = busAddr_q;
  assign o_bus_wdata = busWdata_q;

endmodule

// File: tb/tb_gpu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gpu_bus_arbiter
// Bench for gpu_bus_arbiter (4 masters, read latency 2). A transaction-level
// model predicts, for every cycle, which grant/bus/read-return values must be
// visible; directed phases pin the model with literal expectations and a
// random phase exercises mixed traffic. Lock behaviour follows BUS_ARB_LOCK_EN.
// -----------------------------------------------------------------------------
module tb_gpu_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int L  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N-1:0]         i_req = '0;
  logic [N-1:0]         i_we = '0;
  logic [N-1:0][AW-1:0] i_addr = '0;
  logic [N-1:0][DW-1:0] i_wdata = '0;
  logic [N-1:0]         i_lock = '0;
  logic [N-1:0]         o_gnt;
  logic [N-1:0]         o_rvalid;
  logic [DW-1:0]        o_rdata;
  logic                 o_bus_valid;
  logic                 o_bus_we;
  logic [AW-1:0]        o_bus_addr;
  logic [DW-1:0]        o_bus_wdata;
  logic [DW-1:0]        i_bus_rdata = '0;

  always #5 clk = ~clk;

  gpu_bus_arbiter #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RD_LATENCY (L)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (i_req),
    .i_we        (i_we),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .i_lock      (i_lock),
    .o_gnt       (o_gnt),
    .o_rvalid    (o_rvalid),
    .o_rdata     (o_rdata),
    .o_bus_valid (o_bus_valid),
    .o_bus_we    (o_bus_we),
    .o_bus_addr  (o_bus_addr),
    .o_bus_wdata (o_bus_wdata),
    .i_bus_rdata (i_bus_rdata)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = -1;
  bit randomMode = 1'b0;
  logic [N-1:0] contMask = '0;

  // Directed requests waiting to be raised, and follow-up requests a master
  // raises the moment its current request is granted.
  bit dirPend[N];
  bit dirWe[N];
  logic [AW-1:0] dirAddr[N];
  logic [DW-1:0] dirWdata[N];
  bit folPend[N];
  bit folWe[N];
  logic [AW-1:0] folAddr[N];
  logic [DW-1:0] folWdata[N];

  // Transaction-level model: the cycle of the grant, of the read-data sample
  // and of the read return, plus the cycle from which arbitration may resume.
  int nextArb, gCyc, sCyc, rCyc, pw, lastM;
  bit pwe, locked;
  logic [AW-1:0] paddr, eAddr;
  logic [DW-1:0] pwdata, eWdata, cap, eRdata;
  logic [N-1:0] eGnt;

  int gIdx[$];
  int gCy[$];
  int expOrder[6] = '{2, 3, 0, 1, 2, 3};

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic modelReset();
    nextArb = 0;
    gCyc = -10;
    sCyc = -10;
    rCyc = -10;
    pw = 0;
    lastM = N - 1;
    pwe = 1'b0;
    locked = 1'b0;
    eAddr = '0;
    eWdata = '0;
    eRdata = '0;
    cap = '0;
    eGnt = '0;
  endtask

  task automatic compareCycle();
    eGnt = (cyc == gCyc) ? (N'(1) << pw) : '0;
    if (cyc == gCyc) begin
      eAddr = paddr;
      eWdata = pwdata;
    end
    if (cyc == rCyc) eRdata = cap;
    checkOutput("gnt", 64'(o_gnt), 64'(eGnt));
    checkOutput("bus_valid", 64'(o_bus_valid), 64'(cyc == gCyc));
    checkOutput("bus_we", 64'(o_bus_we), 64'((cyc == gCyc) && pwe));
    checkOutput("bus_addr", 64'(o_bus_addr), 64'(eAddr));
    checkOutput("bus_wdata", 64'(o_bus_wdata), 64'(eWdata));
    checkOutput("rvalid", 64'(o_rvalid), 64'((cyc == rCyc) ? (N'(1) << pw) : N'(0)));
    checkOutput("rdata", 64'(o_rdata), 64'(eRdata));
  endtask

  task automatic loadReq(input int m, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input bit lock);
    i_req[m] = 1'b1;
    i_we[m] = we;
    i_addr[m] = addr;
    i_wdata[m] = wdata;
    i_lock[m] = lock;
  endtask

  task automatic newRandom(input int m);
    loadReq(m, 1'($urandom_range(1, 0)), $urandom, $urandom, $urandom_range(2, 0) == 0);
  endtask

  // Masters react to the grant they see this cycle; others may raise requests.
  task automatic applyStimulus();
    for (int m = 0; m < N; m++) begin
      if (eGnt[m]) begin
        if (folPend[m]) begin
          loadReq(m, folWe[m], folAddr[m], folWdata[m], 1'b0);
          folPend[m] = 1'b0;
        end else if (randomMode && $urandom_range(1, 0) == 1) begin
          newRandom(m);
        end else if (randomMode || !contMask[m]) begin
          i_req[m] = 1'b0;
        end
      end else if (dirPend[m]) begin
        loadReq(m, dirWe[m], dirAddr[m], dirWdata[m], 1'b0);
        dirPend[m] = 1'b0;
      end else if (randomMode && !i_req[m] && $urandom_range(3, 0) == 0) begin
        newRandom(m);
      end
    end
    i_bus_rdata = randomMode ? DW'($urandom) : 32'h1234_5678;
  endtask

  // Arbitration from the rules: search upward from the last winner with
  // wrap-around; a read occupies the bus until its return, a write for 2 cycles.
  task automatic modelTick();
    logic [N-1:0] r;
    bit found;
    int m;
    if (cyc == sCyc) cap = i_bus_rdata;
    if (cyc >= nextArb) begin
      r = i_req;
`ifdef BUS_ARB_LOCK_EN
      if (locked) r = i_req & (N'(1) << pw);
`endif
      found = 1'b0;
      for (int off = 1; off <= N; off++) begin
        m = (lastM + off) % N;
        if (!found && r[m]) begin
          found = 1'b1;
          pw = m;
        end
      end
      if (found) begin
        pwe = i_we[pw];
        paddr = i_addr[pw];
        pwdata = i_wdata[pw];
        lastM = pw;
        gCyc = cyc + 1;
`ifdef BUS_ARB_LOCK_EN
        locked = i_lock[pw];
`endif
        if (pwe) begin
          nextArb = cyc + 2;
        end else begin
          sCyc = cyc + 1 + L;
          rCyc = cyc + 2 + L;
          nextArb = cyc + 3 + L;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    compareCycle();
    applyStimulus();
    modelTick();
  endtask

  task automatic queueReq(input int m, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    dirPend[m] = 1'b1;
    dirWe[m] = we;
    dirAddr[m] = addr;
    dirWdata[m] = wdata;
  endtask

  task automatic queueFollow(input int m, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    folPend[m] = 1'b1;
    folWe[m] = we;
    folAddr[m] = addr;
    folWdata[m] = wdata;
  endtask

  task automatic waitGrant(input int m, input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      if (o_gnt[m]) seen = 1'b1;
    end
    checkOutput(name, 64'(o_gnt), 64'(N'(1) << m));
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_gnt"}, 64'(o_gnt), 64'd0);
    checkOutput({name, "_rvalid"}, 64'(o_rvalid), 64'd0);
    checkOutput({name, "_valid"}, 64'(o_bus_valid), 64'd0);
    checkOutput({name, "_we"}, 64'(o_bus_we), 64'd0);
    checkOutput({name, "_addr"}, 64'(o_bus_addr), 64'd0);
    checkOutput({name, "_wdata"}, 64'(o_bus_wdata), 64'd0);
    checkOutput({name, "_rdata"}, 64'(o_rdata), 64'd0);
  endtask

  initial begin
    for (int m = 0; m < N; m++) begin
      dirPend[m] = 1'b0;
      folPend[m] = 1'b0;
    end
    modelReset();
    #2;
    checkAllZero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    step();

    // Single write from master 0.
    queueReq(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    waitGrant(0, "t1_gnt");
    checkOutput("t1_valid", 64'(o_bus_valid), 64'd1);
    checkOutput("t1_we", 64'(o_bus_we), 64'd1);
    checkOutput("t1_addr", 64'(o_bus_addr), 64'h10);
    checkOutput("t1_wdata", 64'(o_bus_wdata), 64'hDEAD_BEEF);
    step();
    checkOutput("t1_norv", 64'(o_rvalid), 64'd0);

    // Read from master 1; data returns three cycles after the grant.
    queueReq(1, 1'b0, 32'h20, 32'h0);
    waitGrant(1, "t2_gnt");
    checkOutput("t2_we", 64'(o_bus_we), 64'd0);
    repeat (3) step();
    checkOutput("t2_rvalid", 64'(o_rvalid), 64'b0010);
    checkOutput("t2_rdata", 64'(o_rdata), 64'h1234_5678);

    // Continuous writes from all masters, starting with last = 1.
    contMask = '1;
    for (int m = 0; m < N; m++) queueReq(m, 1'b1, AW'(32'h100 + m), DW'(m));
    repeat (14) begin
      step();
      for (int k = 0; k < N; k++) begin
        if (o_gnt[k]) begin
          gIdx.push_back(k);
          gCy.push_back(cyc);
        end
      end
    end
    contMask = '0;
    checkOutput("t3_count", 64'(gIdx.size() >= 6), 64'd1);
    for (int i = 0; i < 6; i++) begin
      checkOutput("t3_order", 64'((i < gIdx.size()) ? gIdx[i] : -1), 64'(expOrder[i]));
      if (i > 0) checkOutput("t3_spacing", 64'((i < gCy.size()) ? gCy[i] - gCy[i-1] : -1), 64'd2);
    end
    repeat (12) step();

    // Reset while a read from master 3 waits for its data.
    queueReq(3, 1'b0, 32'h30, 32'h0);
    waitGrant(3, "t5_gnt");
    step();
    rst_n = 1'b0;
    #1;
    checkAllZero("t5_async");
    i_req = '0;
    modelReset();
    step();
    rst_n = 1'b1;
    queueReq(0, 1'b1, 32'h50, 32'h5);
    queueReq(2, 1'b1, 32'h52, 32'h7);
    step();
    step();
    checkOutput("t5_first", 64'(o_gnt), 64'b0001);
    repeat (8) step();

    // Master 3 reads, then keeps requesting for a write.
    queueReq(3, 1'b0, 32'h40, 32'h0);
    queueFollow(3, 1'b1, 32'h44, 32'hCAFE_F00D);
    waitGrant(3, "t6_rd_gnt");
    repeat (3) step();
    checkOutput("t6_rvalid", 64'(o_rvalid), 64'b1000);
    checkOutput("t6_rdata", 64'(o_rdata), 64'h1234_5678);
    step();
    checkOutput("t6_gap", 64'(o_gnt), 64'd0);
    step();
    checkOutput("t6_wr_gnt", 64'(o_gnt), 64'b1000);
    checkOutput("t6_wr_we", 64'(o_bus_we), 64'd1);
    checkOutput("t6_wr_addr", 64'(o_bus_addr), 64'h44);
    checkOutput("t6_rdata_held", 64'(o_rdata), 64'h1234_5678);
    repeat (4) step();

    // Random mixed traffic against the model.
    randomMode = 1'b1;
    repeat (3000) step();
    randomMode = 1'b0;
    repeat (40) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
